// File: rtl/rock_profile_gen.sv
// Frame-synchronous rocking-motion pulse-width generator for a downstream PWM block.
// Optional feature: define ROCK_SOFTSTART_EN to ramp the swing up over four cycles.
module rock_profile_gen #(
    parameter int unsigned PERIOD  = 24000,
    parameter int unsigned CENTRE  = 1800,
    parameter int unsigned AMP_MAX = 600,
    parameter int unsigned DWELL   = 25
) (
    input  logic        CLK,
    input  logic        resetmore,
    input  logic        Enable,
    input  logic [3:0]  Step,
    input  logic [15:0] Amp,
    output logic [15:0] Duty,
    output logic        Frame,
    output logic        Busy
);
    localparam int unsigned DW  = 16;
    localparam int unsigned IW  = 17;
    localparam int unsigned FCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [FCW-1:0] FC_LAST = FCW'(PERIOD - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DWELL - 1);
    localparam logic [IW-1:0]  CTR     = IW'(CENTRE);
    localparam logic [DW-1:0]  AMAX    = DW'(AMP_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO, S_RETURN
    } state_t;

    state_t         state, state_nxt;
    logic [FCW-1:0] fc, fc_nxt;
    logic [DCW-1:0] dcnt, dcnt_nxt;
    logic [DW-1:0]  amp_a, amp_a_nxt, amp_clamp, duty_nxt;
    logic [IW-1:0]  s, a_eff, a_eff_new, hi_lim, hi_new, lo_lim;
    logic [IW-1:0]  duty_x, up_val, dn_val, ret_val;
    logic           ret_done, tick;

    assign tick      = Frame;
    assign fc_nxt    = (fc == FC_LAST) ? '0 : fc + FCW'(1);
    assign s         = (Step == 4'd0) ? IW'(1) : IW'(Step);
    assign amp_clamp = (Amp > AMAX) ? AMAX : Amp;

`ifdef ROCK_SOFTSTART_EN
    // Leg counter k scales the latched amplitude by k/4
    localparam int unsigned PW = IW + 3;
    logic [2:0]    leg_k, leg_k_nxt;
    logic [PW-1:0] leg_prod;
    assign leg_prod  = PW'(leg_k) * PW'(amp_a);
    assign a_eff     = IW'(leg_prod >> 2);
    assign a_eff_new = IW'(amp_clamp >> 2);
`else
    assign a_eff     = IW'(amp_a);
    assign a_eff_new = IW'(amp_clamp);
`endif

    assign duty_x = {1'b0, Duty};
    assign up_val = duty_x + s;
    assign dn_val = duty_x - s;
    assign hi_lim = CTR + a_eff;
    assign hi_new = CTR + a_eff_new;
    assign lo_lim = CTR - a_eff;

    // One step toward centre, saturating there
    assign ret_done = (duty_x > CTR) ? (duty_x <= CTR + s) : (up_val >= CTR);
    assign ret_val  = ret_done ? CTR : ((duty_x > CTR) ? dn_val : up_val);

    always_ff @(posedge CLK or posedge resetmore) begin
        if (resetmore) begin
            fc    <= '0;
            Frame <= 1'b0;
            state <= S_IDLE;
            Busy  <= 1'b0;
            Duty  <= DW'(CENTRE);
            amp_a <= '0;
            dcnt  <= '0;
`ifdef ROCK_SOFTSTART_EN
            leg_k <= '0;
`endif
        end else begin
            fc    <= fc_nxt;
            Frame <= (fc_nxt == FC_LAST);
            if (tick) begin
                state <= state_nxt;
                Busy  <= (state_nxt != S_IDLE);
                Duty  <= duty_nxt;
                amp_a <= amp_a_nxt;
                dcnt  <= dcnt_nxt;
`ifdef ROCK_SOFTSTART_EN
                leg_k <= leg_k_nxt;
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        duty_nxt  = Duty;
        dcnt_nxt  = dcnt;
        amp_a_nxt = amp_a;
`ifdef ROCK_SOFTSTART_EN
        leg_k_nxt = leg_k;
`endif
        if ((state inside {S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO}) && !Enable) begin
            duty_nxt  = DW'(ret_val);
            state_nxt = ret_done ? S_IDLE : S_RETURN;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Enable) begin
                        amp_a_nxt = amp_clamp;
`ifdef ROCK_SOFTSTART_EN
                        leg_k_nxt = 3'd1;
`endif
                        if (up_val >= hi_new) begin
                            duty_nxt  = DW'(hi_new);
                            dcnt_nxt  = '0;
                            state_nxt = S_DWELL_HI;
                        end else begin
                            duty_nxt  = DW'(up_val);
                            state_nxt = S_UP;
                        end
                    end
                end
                S_UP: begin
                    if (up_val >= hi_lim) begin
                        duty_nxt  = DW'(hi_lim);
                        dcnt_nxt  = '0;
                        state_nxt = S_DWELL_HI;
                    end else begin
                        duty_nxt = DW'(up_val);
                    end
                end
                S_DWELL_HI: begin
                    if (dcnt == DC_LAST) begin
                        state_nxt = S_DOWN;
                    end else begin
                        dcnt_nxt = dcnt + DCW'(1);
                    end
                end
                S_DOWN: begin
                    if (duty_x <= lo_lim + s) begin
                        duty_nxt  = DW'(lo_lim);
                        dcnt_nxt  = '0;
                        state_nxt = S_DWELL_LO;
                    end else begin
                        duty_nxt = DW'(dn_val);
                    end
                end
                S_DWELL_LO: begin
                    if (dcnt == DC_LAST) begin
                        amp_a_nxt = amp_clamp;
`ifdef ROCK_SOFTSTART_EN
                        leg_k_nxt = (leg_k == 3'd4) ? 3'd4 : leg_k + 3'd1;
`endif
                        state_nxt = S_UP;
                    end else begin
                        dcnt_nxt = dcnt + DCW'(1);
                    end
                end
                S_RETURN: begin
                    duty_nxt = DW'(ret_val);
                    if (ret_done) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
